// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer.
package word_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int   DEF_WIDTH    = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

  // Counter must reach WIDTH to hold the parity slot index.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: one bit per clock, idle bit when no word is in flight.
// Optional trailing even-parity bit per frame when WORD_SERIALIZER_PARITY_EN is defined.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);
  localparam logic [CW-1:0] DATA_END = CW'(WIDTH - 1);

  ser_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_bit, r_bvalid, r_fstart;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             r_par;
`endif

  logic w_accept, w_last, w_first, w_next;

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = in_valid & in_ready;
  assign w_first  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  // Head of the register after the pending shift.
  assign w_next   = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SER_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SER_IDLE:  if (w_accept)            w_state_nxt = SER_SHIFT;
      SER_SHIFT: if (w_last && !w_accept) w_state_nxt = SER_IDLE;
      default:                            w_state_nxt = SER_IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst & ((r_state == SER_IDLE) | ((r_state == SER_SHIFT) & w_last));
    busy     = (r_state != SER_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_bit    <= IDLE_BIT;
      r_bvalid <= 1'b0;
      r_fstart <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shift  <= in_data;
      r_cnt    <= '0;
      r_bit    <= w_first;
      r_bvalid <= 1'b1;
      r_fstart <= 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
      r_par    <= ^in_data;
`endif
    end else if (r_state == SER_SHIFT) begin
      if (!w_last) begin
        r_shift  <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
        r_cnt    <= r_cnt + CW'(1);
        r_fstart <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        r_bit    <= (r_cnt == DATA_END) ? r_par : w_next;
`else
        r_bit    <= w_next;
`endif
      end else begin
        r_bit    <= IDLE_BIT;
        r_bvalid <= 1'b0;
        r_fstart <= 1'b0;
      end
    end
  end

  assign bit_out     = r_bit;
  assign bit_valid   = r_bvalid;
  assign frame_start = r_fstart;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: frame-level queue model checked every cycle plus literal frame checks.
module tb_word_serializer;

  localparam int W = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic         a_ready, a_bit, a_bv, a_fs, a_busy;
  logic         b_ready, b_bit, b_bv, b_fs, b_busy;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .bit_out(a_bit), .bit_valid(a_bv), .frame_start(a_fs), .busy(a_busy));

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .bit_out(b_bit), .bit_valid(b_bv), .frame_start(b_fs), .busy(b_busy));

  int vectors = 0;
  int errors  = 0;

  // Model: pending frame entries {frame_start,bit}; cur = entry on the wire, -1 when idle.
  int qa[$], qb[$];
  int ca = -1, cb = -1;
  int loga[$], logb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int frame_ent(input logic [W-1:0] w, input bit msb, input int k);
    logic b;
    if (k >= W) b = ^w;
    else        b = msb ? w[W-1-k] : w[k];
    return ((k == 0) ? 2 : 0) + (b ? 1 : 0);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      qa.delete(); qb.delete();
      ca = -1; cb = -1;
    end else begin
      if (a_valid && qa.size() == 0)
        for (int k = 0; k < FL; k++) qa.push_back(frame_ent(a_data, 1'b0, k));
      if (b_valid && qb.size() == 0)
        for (int k = 0; k < FL; k++) qb.push_back(frame_ent(b_data, 1'b1, k));
      ca = (qa.size() > 0) ? qa.pop_front() : -1;
      cb = (qb.size() > 0) ? qb.pop_front() : -1;
    end
  end

  task automatic cmp(input string tag, input logic rdy, input logic bo, input logic bv,
                     input logic fs, input logic bsy, input int cur, input int qs,
                     input logic idle);
    logic v;
    v = (cur >= 0);
    chk({tag, ".in_ready"},    rdy, rst && (qs == 0));
    chk({tag, ".bit_valid"},   bv,  v);
    chk({tag, ".bit_out"},     bo,  v ? cur[0] : idle);
    chk({tag, ".frame_start"}, fs,  v && cur[1]);
    chk({tag, ".busy"},        bsy, v);
  endtask

  initial forever begin
    @(negedge clk);
    cmp("A", a_ready, a_bit, a_bv, a_fs, a_busy, ca, qa.size(), 1'b0);
    cmp("B", b_ready, b_bit, b_bv, b_fs, b_busy, cb, qb.size(), 1'b1);
    loga.push_back(int'({a_busy, a_fs, a_bv, a_bit}));
    logb.push_back(int'({b_busy, b_fs, b_bv, b_bit}));
  end

  task automatic send_a(input logic [W-1:0] w);
    a_data = w; a_valid = 1'b1;
    @(posedge clk); #2;
    a_valid = 1'b0;
    loga.delete();
  endtask

  task automatic send_b(input logic [W-1:0] w);
    b_data = w; b_valid = 1'b1;
    @(posedge clk); #2;
    b_valid = 1'b0;
    logb.delete();
  endtask

  // Reassemble the data bits of a logged frame, LSB-first or MSB-first.
  function automatic logic [W-1:0] gather(input int lg[$], input bit msb);
    logic [W-1:0] w;
    int e;
    w = '0;
    for (int k = 0; k < W; k++) begin
      e = lg[k];
      if (msb) w = {w[W-2:0], e[0]};
      else     w[k] = e[0];
    end
    return w;
  endfunction

  initial begin
    int e, nfs, nbusy, nv, x;

    // Reset held with valid asserted
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h5A; b_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_a", a_ready, 1'b0);
    chk("rst_bit_b_idle", b_bit, 1'b1);
    #1;
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("release_ready_a", a_ready, 1'b1);
    chk("release_ready_b", b_ready, 1'b1);

    // Single word, LSB first
    @(posedge clk); #2;
    send_a(8'hA5);
    repeat (FL + 1) @(negedge clk);
    #1;
    chk("a5_bits", gather(loga, 1'b0), 8'hA5);
    nfs = 0;
    for (int k = 0; k < FL; k++) begin e = loga[k]; nfs += e[2]; end
    e = loga[0];
    chk("a5_fs_first", e[2], 1'b1);
    chk("a5_fs_count", nfs, 1);
    e = loga[FL];
    chk("a5_tail_invalid", e[1], 1'b0);

    // MSB first, idle bit 1
    @(posedge clk); #2;
    send_b(8'h81);
    repeat (FL + 2) @(negedge clk);
    #1;
    chk("b81_bits", gather(logb, 1'b1), 8'h81);
    nbusy = 0;
    for (int k = 0; k < FL + 2; k++) begin e = logb[k]; nbusy += e[3]; end
    chk("b81_busy_cycles", nbusy, FL);
    e = logb[FL];
    chk("b81_idle_bit", e[0], 1'b1);

    // Back-to-back FF then 00
    @(posedge clk); #2;
    a_data = 8'hFF; a_valid = 1'b1;
    @(posedge clk); #2;
    a_data = 8'h00; loga.delete();
    repeat (FL) @(posedge clk);
    #2 a_valid = 1'b0;
    repeat (FL + 1) @(negedge clk);
    #1;
    nv = 0; nfs = 0;
    for (int k = 0; k < 2 * FL; k++) begin e = loga[k]; nv += e[1]; nfs += e[2]; end
    chk("b2b_valid_run", nv, 2 * FL);
    chk("b2b_fs_count", nfs, 2);
    e = loga[FL];
    chk("b2b_fs_second", e[2], 1'b1);
    e = loga[W - 1];
    chk("b2b_first_last_data", e[0], 1'b1);
    e = loga[FL];
    chk("b2b_second_first_data", e[0], 1'b0);
    e = loga[2 * FL];
    chk("b2b_tail_invalid", e[1], 1'b0);

    // Mid-frame reset after 3 bits of F0
    @(posedge clk); #2;
    send_a(8'hF0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_bv", a_bv, 1'b0);
    chk("midrst_fs", a_fs, 1'b0);
    chk("midrst_bit", a_bit, 1'b0);
    chk("midrst_ready", a_ready, 1'b0);
    chk("midrst_busy", a_busy, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2;
    send_a(8'h3C);
    repeat (FL + 1) @(negedge clk);
    #1;
    chk("after_rst_bits", gather(loga, 1'b0), 8'h3C);
    e = loga[0];
    chk("after_rst_fs", e[2], 1'b1);

`ifdef WORD_SERIALIZER_PARITY_EN
    @(posedge clk); #2;
    send_a(8'h07);
    repeat (FL + 1) @(negedge clk);
    #1;
    e = loga[W];
    chk("par07_bit", e[0], 1'b1);
    chk("par07_valid", e[1], 1'b1);
    chk("par07_fs", e[2], 1'b0);
    x = 0; nv = 0;
    for (int k = 0; k < FL + 1; k++) begin e = loga[k]; nv += e[1]; if (e[1]) x ^= e[0]; end
    chk("par07_nvalid", nv, 9);
    chk("par07_xor", x, 0);
    @(posedge clk); #2;
    send_a(8'h03);
    repeat (FL + 1) @(negedge clk);
    #1;
    e = loga[W];
    chk("par03_bit", e[0], 1'b0);
    x = 0;
    for (int k = 0; k < FL; k++) begin e = loga[k]; x ^= e[0]; end
    chk("par03_xor", x, 0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial front stage that directly feeds the serial running-XOR stage.
- Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per clock.
- The downstream stage consumes a bit every cycle unconditionally, so an idle bit is driven whenever no word is in flight.
- Frame markers (bit_valid, frame_start) let downstream or test logic align words.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..64
MSB_FIRST, 0, 1 = emit in_data[WIDTH-1] first; 0 = emit in_data[0] first
IDLE_BIT, 1'b0, value driven on bit_out when no word is being shifted

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  upstream word valid
in_data  input  WIDTH  word to serialize; sampled only on accept
in_ready  output  1  block can accept a word this cycle
bit_out  output  1  serial bit to downstream stage, registered
bit_valid  output  1  bit_out carries a data (or parity) bit, registered
frame_start  output  1  bit_out is the first bit of a frame, registered
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, shift register=0, bit counter=0, bit_out=IDLE_BIT, bit_valid=0, frame_start=0.
- in_ready is forced 0 while rst=0. It is deasserted by the reset condition and released only when rst=1.
- FSM has two states, IDLE and SHIFT. Frame length FL=WIDTH; FL=WIDTH+1 with the parity option.
- in_ready = rst & (state==IDLE | (state==SHIFT & cnt==FL-1)). Combinational; does not depend on in_valid.
- Accept = in_valid & in_ready, evaluated at the rising edge.
  - On accept, load the shift register with in_data.
  - bit_out <= first bit, bit_valid <= 1, frame_start <= 1, cnt <= 0, state <= SHIFT.
- Latency: the first bit appears on bit_out in the cycle after the accept edge. Bit k of the frame appears k cycles later.
- SHIFT, no accept, cnt<FL-1: shift by one, bit_out <= next bit, cnt <= cnt+1, frame_start <= 0.
- SHIFT, cnt==FL-1, no accept: state <= IDLE, bit_out <= IDLE_BIT, bit_valid <= 0, frame_start <= 0.
- SHIFT, cnt==FL-1, accept (back-to-back):
  - load the new word and emit its first bit with frame_start=1.
  - Zero-gap streaming; state remains SHIFT.
- IDLE with no accept: outputs hold IDLE_BIT / 0 / 0.
- in_data and in_valid are ignored when in_ready=0; no buffering beyond the single shift register.
- Counter width = $clog2(WIDTH+1). It never wraps past FL-1.
- Reset mid-frame: the partial frame is discarded; outputs take reset values immediately, asynchronously.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN.
- Defined: each frame is WIDTH data bits followed by one even-parity bit (XOR of all WIDTH bits of the accepted word).
  - The parity bit is computed at accept and stored.
  - It is emitted at cnt==WIDTH with bit_valid=1, frame_start=0.
  - FL=WIDTH+1; the back-to-back accept point moves to the parity cycle.
- Undefined: no parity storage or logic, FL=WIDTH.

Decomposition:
- Package word_serializer_pkg:
  - state enum ser_state_e {SER_IDLE, SER_SHIFT}
  - function cnt_width(WIDTH)
  - localparam defaults for WIDTH and IDLE_BIT
- No sub-module: the shift register, counter and parity XOR are small enough to stay in one module.

Test Plan:
- Reset behaviour: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=0, bit_out=IDLE_BIT, bit_valid=0. Release -> in_ready=1 the next cycle.
- Single word: WIDTH=8, MSB_FIRST=0, accept 8'hA5 -> bit_out 1,0,1,0,0,1,0,1 on the 8 cycles after accept; frame_start only on the first; then bit_valid=0.
- MSB-first ordering: MSB_FIRST=1, accept 8'h81 -> 1,0,0,0,0,0,0,1; busy high for exactly 8 cycles.
- Back-to-back: in_valid held with 8'hFF then 8'h00 -> 16 consecutive bit_valid cycles, no gap; frame_start at cycles 1 and 9; in_ready high only in IDLE and on the last-bit cycle.
- Mid-frame reset: assert rst=0 after 3 bits of 8'hF0 -> outputs take reset values immediately; after release the next accepted word serializes from its bit 0.
- Parity (WORD_SERIALIZER_PARITY_EN): accept 8'h07 -> 8 data bits then parity 1 (9 valid bits). Accept 8'h03 -> parity 0. The downstream XOR of each frame equals 0.
